syscall_console: RTL and testbench

SYSCALL_CONSOLE -- requirements
Module: syscall_console

---
 rtl/syscall_console.sv | 160 ++++++++++++++++
 tb/tb_syscall_console.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_console.sv
// Console syscall unit: prints signed integers and characters as ASCII bytes over a
// valid/ready byte stream, and latches exit and unsupported-function conditions.
module syscall_console (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param,
    output logic        syscall_busy,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted,
    output logic        bad_funct
);

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        DIGIT,
        EMIT,
        CHAR,
        HALT
    } state_t;

    state_t      stateReg, stateNext;
    logic [31:0] magReg, magNext;
    logic [3:0]  powIdxReg, powIdxNext;
    logic [3:0]  digitReg, digitNext;
    logic        startedReg, startedNext;
    logic [7:0]  byteReg, byteNext;
    logic        haltedReg, haltedNext;
    logic        badFunctReg, badFunctNext;

    logic [31:0] curPow;
    logic        xfer;

    function automatic logic [31:0] powerOfTen(input logic [3:0] idx);
        case (idx)
            4'd0:    powerOfTen = 32'd1;
            4'd1:    powerOfTen = 32'd10;
            4'd2:    powerOfTen = 32'd100;
            4'd3:    powerOfTen = 32'd1000;
            4'd4:    powerOfTen = 32'd10000;
            4'd5:    powerOfTen = 32'd100000;
            4'd6:    powerOfTen = 32'd1000000;
            4'd7:    powerOfTen = 32'd10000000;
            4'd8:    powerOfTen = 32'd100000000;
            default: powerOfTen = 32'd1000000000;
        endcase
    endfunction

    assign curPow       = powerOfTen(powIdxReg);
    assign out_valid    = (stateReg == SIGN) || (stateReg == EMIT) || (stateReg == CHAR);
    assign xfer         = out_valid && out_ready;
    assign out_byte     = byteReg;
    assign syscall_busy = (stateReg != IDLE);
    assign halted       = haltedReg;
    assign bad_funct    = badFunctReg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg    <= IDLE;
            magReg      <= '0;
            powIdxReg   <= '0;
            digitReg    <= '0;
            startedReg  <= 1'b0;
            byteReg     <= '0;
            haltedReg   <= 1'b0;
            badFunctReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            magReg      <= magNext;
            powIdxReg   <= powIdxNext;
            digitReg    <= digitNext;
            startedReg  <= startedNext;
            byteReg     <= byteNext;
            haltedReg   <= haltedNext;
            badFunctReg <= badFunctNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        magNext      = magReg;
        powIdxNext   = powIdxReg;
        digitNext    = digitReg;
        startedNext  = startedReg;
        byteNext     = byteReg;
        haltedNext   = haltedReg;
        badFunctNext = badFunctReg;

        case (stateReg)
            IDLE: begin
                if (syscall_valid && !haltedReg) begin
                    case (syscall_funct)
                        32'd1: begin
                            powIdxNext  = 4'd9;
                            digitNext   = 4'd0;
                            startedNext = 1'b0;
                            // Two's-complement negate; 0x80000000 maps onto itself as unsigned 2^31.
                            if (syscall_param[31]) begin
                                magNext   = 32'd0 - syscall_param;
                                byteNext  = 8'h2D;
                                stateNext = SIGN;
                            end else begin
                                magNext   = syscall_param;
                                stateNext = DIGIT;
                            end
                        end
                        32'd11: begin
                            byteNext  = syscall_param[7:0];
                            stateNext = CHAR;
                        end
                        32'd10, 32'd17: begin
                            haltedNext = 1'b1;
                            stateNext  = HALT;
                        end
                        default: badFunctNext = 1'b1;
                    endcase
                end
            end
            SIGN: begin
                if (xfer) stateNext = DIGIT;
            end
            DIGIT: begin
                if (magReg >= curPow && digitReg != 4'd9) begin
                    magNext   = magReg - curPow;
                    digitNext = digitReg + 4'd1;
                end else if (digitReg != 4'd0 || startedReg || powIdxReg == 4'd0) begin
                    byteNext    = 8'h30 + {4'h0, digitReg};
                    startedNext = 1'b1;
                    stateNext   = EMIT;
                end else begin
                    // Leading zero: skip straight to the next power of ten.
                    powIdxNext = powIdxReg - 4'd1;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (powIdxReg == 4'd0) begin
                        stateNext = IDLE;
                    end else begin
                        powIdxNext = powIdxReg - 4'd1;
                        digitNext  = 4'd0;
                        stateNext  = DIGIT;
                    end
                end
            end
            CHAR: begin
                if (xfer) stateNext = IDLE;
            end
            HALT: begin
                stateNext = HALT;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: expected console text comes from
// formatting the request value as a decimal string, compared to captured bytes.
module tb_syscall_console;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        syscall_valid = 1'b0;
    logic [31:0] syscall_funct = '0;
    logic [31:0] syscall_param = '0;
    logic        syscall_busy;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        halted;
    logic        bad_funct;

    int errors = 0;
    int checks = 0;
    int readyMode = 0;
    byte unsigned capQ[$];
    logic        prevStall = 1'b0;
    logic [7:0]  prevByte = '0;
    logic [31:0] edgeVals [8] = '{32'd0, 32'd9, 32'd10, 32'd999999999, 32'd1000000000,
                                  32'h7FFFFFFF, 32'hFFFFFFF6, 32'hC4653600};

    syscall_console dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .syscall_valid (syscall_valid),
        .syscall_funct (syscall_funct),
        .syscall_param (syscall_param),
        .syscall_busy  (syscall_busy),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .halted        (halted),
        .bad_funct     (bad_funct)
    );

    always #5 clock = ~clock;

    // Sink: ready pattern changes on the falling edge.
    initial forever begin
        @(negedge clock);
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: values seen just after the falling edge are those present at the next rising edge.
    initial forever begin
        @(negedge clock);
        #1;
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== prevByte) begin
                    errors++;
                    $display("FAIL hold_stable: out_valid=%b out_byte=%02h, required out_valid=1 out_byte=%02h",
                             out_valid, out_byte, prevByte);
                end
            end
            if (out_valid === 1'b1 && out_ready) capQ.push_back(out_byte);
            prevStall = (out_valid === 1'b1) && !out_ready;
            prevByte  = out_byte;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic string drained();
        string s = "";
        foreach (capQ[i]) s = {s, $sformatf("%c", capQ[i])};
        capQ.delete();
        return s;
    endfunction

    task automatic issue(input logic [31:0] f, input logic [31:0] p);
        @(negedge clock);
        syscall_funct = f;
        syscall_param = p;
        syscall_valid = 1'b1;
        @(negedge clock);
        syscall_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (1) begin
            @(negedge clock);
            #2;
            if (syscall_busy === 1'b0) break;
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: syscall_busy=%b after %0d cycles, required 0", name, syscall_busy, n);
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #2;
        checks++; if (syscall_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", syscall_busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %02h required 00", out_byte); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++; if (bad_funct !== 1'b0) begin errors++; $display("FAIL reset_bad_funct: got %b required 0", bad_funct); end
        reset_n = 1'b1;
    endtask

    task automatic test_print_char();
        string got;
        readyMode = 0;
        capQ.delete();
        issue(32'd11, 32'h41);
        wait_idle("print_char");
        got = drained();
        $display("txn funct=11 param=00000041 bytes=\"%s\"", got);
        checks++; if (got != "A") begin errors++; $display("FAIL print_char: got \"%s\" required \"A\"", got); end
        checks++; if (syscall_busy !== 1'b0) begin errors++; $display("FAIL print_char_busy: got %b required 0", syscall_busy); end
    endtask

    task automatic test_print_int_fixed();
        logic [31:0] vals [4] = '{32'd0, 32'd1007, 32'h80000000, 32'hFFFFFFFF};
        string exps [4] = '{"0", "1007", "-2147483648", "-1"};
        string got;
        for (int i = 0; i < 4; i++) begin
            readyMode = (i == 1) ? 1 : 0;
            capQ.delete();
            issue(32'd1, vals[i]);
            wait_idle("print_int_fixed");
            got = drained();
            $display("txn funct=1 param=%08h bytes=\"%s\"", vals[i], got);
            checks++;
            if (got != exps[i]) begin
                errors++;
                $display("FAIL print_int_%08h: got \"%s\" required \"%s\"", vals[i], got, exps[i]);
            end
        end
        readyMode = 0;
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [31:0] f;
        string exp, got;
        for (int i = 0; i < 24; i++) begin
            readyMode = 2;
            case ($urandom_range(0, 4))
                0:       p = $urandom;
                1:       p = $urandom_range(0, 99);
                2:       p = 32'd0 - 32'($urandom_range(1, 99999));
                3:       p = edgeVals[$urandom_range(0, 7)];
                default: p = 32'($urandom_range(33, 126));
            endcase
            if (i % 5 == 4) begin
                f   = 32'd11;
                exp = $sformatf("%c", p[7:0]);
            end else begin
                f   = 32'd1;
                exp = $sformatf("%0d", $signed(p));
            end
            capQ.delete();
            issue(f, p);
            wait_idle("random");
            got = drained();
            $display("txn funct=%0d param=%08h bytes=\"%s\"", f, p, got);
            checks++;
            if (got != exp) begin
                errors++;
                $display("FAIL random_%0d: funct=%0d param=%08h got \"%s\" required \"%s\"", i, f, p, got, exp);
            end
        end
        readyMode = 0;
    endtask

    task automatic test_back_to_back();
        string got;
        readyMode = 0;
        capQ.delete();
        // Held request: accept, handshake (request dropped), accept again, ... over six edges.
        @(negedge clock);
        syscall_funct = 32'd11;
        syscall_param = 32'h50;
        syscall_valid = 1'b1;
        repeat (6) @(negedge clock);
        syscall_valid = 1'b0;
        wait_idle("back_to_back");
        got = drained();
        $display("txn held funct=11 param=00000050 bytes=\"%s\"", got);
        checks++; if (got != "PPP") begin errors++; $display("FAIL back_to_back: got \"%s\" required \"PPP\"", got); end
    endtask

    task automatic test_bad_funct();
        string got;
        readyMode = 0;
        capQ.delete();
        issue(32'd99, 32'h41);
        #2;
        checks++; if (bad_funct !== 1'b1) begin errors++; $display("FAIL bad_funct_set: got %b required 1", bad_funct); end
        checks++; if (syscall_busy !== 1'b0) begin errors++; $display("FAIL bad_funct_busy: got %b required 0", syscall_busy); end
        repeat (3) @(negedge clock);
        #2;
        checks++; if (capQ.size() != 0) begin errors++; $display("FAIL bad_funct_nobyte: got %0d bytes required 0", capQ.size()); end
        capQ.delete();
        issue(32'd11, 32'h42);
        wait_idle("after_bad");
        got = drained();
        $display("txn funct=11 param=00000042 bytes=\"%s\"", got);
        checks++; if (got != "B") begin errors++; $display("FAIL after_bad_char: got \"%s\" required \"B\"", got); end
        checks++; if (bad_funct !== 1'b1) begin errors++; $display("FAIL bad_funct_sticky: got %b required 1", bad_funct); end
    endtask

    task automatic test_reset_mid_print();
        string got;
        readyMode = 0;
        capQ.delete();
        issue(32'd1, 32'd123456);
        repeat (10) @(negedge clock);
        #2;
        checks++; if (syscall_busy !== 1'b1) begin errors++; $display("FAIL midprint_busy: got %b required 1", syscall_busy); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b required 0", out_valid); end
        checks++; if (syscall_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b required 0", syscall_busy); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL async_byte: got %02h required 00", out_byte); end
        checks++; if (bad_funct !== 1'b0) begin errors++; $display("FAIL async_bad_funct: got %b required 0", bad_funct); end
        repeat (2) @(negedge clock);
        #3;
        capQ.delete();
        reset_n = 1'b1;
        syscall_funct = 32'd11;
        syscall_param = 32'h43;
        syscall_valid = 1'b1;
        @(negedge clock);
        syscall_valid = 1'b0;
        wait_idle("after_reset");
        repeat (20) @(negedge clock);
        #2;
        got = drained();
        $display("txn funct=11 param=00000043 bytes=\"%s\"", got);
        checks++; if (got != "C") begin errors++; $display("FAIL after_reset_char: got \"%s\" required \"C\"", got); end
    endtask

    task automatic test_exit();
        readyMode = 0;
        capQ.delete();
        issue(32'd10, 32'd0);
        #2;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL exit10_halted: got %b required 1", halted); end
        checks++; if (syscall_busy !== 1'b1) begin errors++; $display("FAIL exit10_busy: got %b required 1", syscall_busy); end
        issue(32'd11, 32'h44);
        repeat (20) @(negedge clock);
        #2;
        checks++; if (capQ.size() != 0) begin errors++; $display("FAIL halted_nobyte: got %0d bytes required 0", capQ.size()); end
        checks++; if (syscall_busy !== 1'b1) begin errors++; $display("FAIL halted_busy: got %b required 1", syscall_busy); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky: got %b required 1", halted); end
        $display("txn funct=10 then funct=11 bytes=%0d", capQ.size());
        reset_n = 1'b0;
        #3;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL exit_reset_halted: got %b required 0", halted); end
        @(negedge clock);
        reset_n = 1'b1;
        issue(32'd17, 32'd0);
        #2;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL exit17_halted: got %b required 1", halted); end
        checks++; if (syscall_busy !== 1'b1) begin errors++; $display("FAIL exit17_busy: got %b required 1", syscall_busy); end
        $display("txn funct=17 halted=%b", halted);
    endtask

    initial begin
        test_reset();
        test_print_char();
        test_print_int_fixed();
        test_random();
        test_back_to_back();
        test_bad_funct();
        test_reset_mid_print();
        test_exit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
